// File: rtl/gemm_dsp_pkg.sv
// gemm_dsp_pkg: shared defaults, result bundle and the
// round/saturate helper for the DSP58 GeMM column drain.
package gemm_dsp_pkg;

  localparam int Y_DATA_WIDTH_DEF = 58;
  localparam int OUT_WIDTH_DEF    = 32;

  typedef struct packed {
    logic                            last;
    logic signed [OUT_WIDTH_DEF-1:0] data;
  } result_t;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] data;
  } sat_rnd_t;

  // Round half up by 'shift', then clamp to a signed
  // out_w range. Worked at 65 bits so the rounding add
  // can never wrap for any input up to 64 bits.
  function automatic sat_rnd_t sat_round(
    input logic signed [63:0] y,
    input int unsigned        shift,
    input int unsigned        out_w
  );
    logic signed [64:0] r;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    sat_rnd_t           res;
    r = 65'(y);
    if (shift > 0)
      r = (r + (65'sd1 <<< (shift - 1))) >>> shift;
    hi = (65'sd1 <<< (out_w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (out_w - 1));
    res.sat = (r > hi) || (r < lo);
    unique case (1'b1)
      (r > hi): res.data = hi[63:0];
      (r < lo): res.data = lo[63:0];
      default:  res.data = r[63:0];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gemm_sync_fifo.sv
// gemm_sync_fifo: single-clock first-word-fall-through
// buffer; the head word is visible whenever not empty.
// Ports: push/push_data write, pop consumes the head,
// pop_data is the head (0 when empty), full/empty/level.
module gemm_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = level == LW'(DEPTH);
  assign empty    = level == '0;
  assign do_pop   = pop && !empty;
  // A full buffer still takes a word when the head
  // leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        do_push && !do_pop: level <= level + LW'(1);
        do_pop && !do_push: level <= level - LW'(1);
        default:            level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dsp58_col_result_drain.sv
// dsp58_col_result_drain: captures the column's P output a
// fixed delay after last_k, rounds/saturates it, and streams
// it out with TLAST every TILE_N results.
// Ports: last_k/y_data from the column, clr_flags clears the
// sticky sat_flag/ovf_err, m_t* is the output stream,
// fifo_level is the buffered entry count.
module dsp58_col_result_drain
  import gemm_dsp_pkg::*;
#(
  parameter int Y_DATA_WIDTH = Y_DATA_WIDTH_DEF,
  parameter int OUT_WIDTH    = OUT_WIDTH_DEF,
  parameter int SHIFT        = 0,
  parameter int PIPE_LAT     = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int TILE_N       = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          last_k,
  input  logic signed [Y_DATA_WIDTH-1:0] y_data,
  input  logic                          clr_flags,
  output logic [OUT_WIDTH-1:0]          m_tdata,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  input  logic                          m_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          sat_flag,
  output logic                          ovf_err
);

  localparam int TW = (TILE_N > 1) ? $clog2(TILE_N) : 1;

  typedef struct packed {
    logic                 last;
    logic [OUT_WIDTH-1:0] data;
  } col_res_t;

  logic [PIPE_LAT-1:0] dly;
  logic                cap;
  logic [TW-1:0]       tile_idx;
  logic                tile_end;
  sat_rnd_t            sr;
  logic                unused_sr;
  logic                s1_vld;
  col_res_t            s1;
  col_res_t            head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                drop;

  assign cap      = dly[PIPE_LAT-1];
  assign tile_end = tile_idx == TW'(TILE_N - 1);
  assign sr       = sat_round(64'(y_data), SHIFT, OUT_WIDTH);
  // Bits above OUT_WIDTH are only sign copies after clamping.
  assign unused_sr = ^sr.data[63:OUT_WIDTH];

  assign pop  = m_tvalid && m_tready;
  assign drop = s1_vld && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly      <= '0;
      tile_idx <= '0;
      s1_vld   <= 1'b0;
      s1       <= '0;
      sat_flag <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      dly    <= PIPE_LAT'({dly, last_k});
      s1_vld <= cap;
      // The tile position advances even if this result is
      // later dropped, so framing stays aligned to strobes.
      if (cap) begin
        s1.last  <= tile_end;
        s1.data  <= sr.data[OUT_WIDTH-1:0];
        tile_idx <= tile_end ? '0 : tile_idx + TW'(1);
      end
      sat_flag <= (sat_flag && !clr_flags) || (cap && sr.sat);
      ovf_err  <= (ovf_err && !clr_flags) || drop;
    end
  end

  gemm_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(col_res_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s1_vld),
    .push_data (s1),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign m_tvalid = !fifo_empty;
  assign m_tdata  = head.data;
  assign m_tlast  = head.last;

endmodule

// File: tb/tb_dsp58_col_result_drain.sv
// tb_dsp58_col_result_drain: two instances (SHIFT 0 and 4)
// driven in lockstep and checked against a queue model.
module tb_dsp58_col_result_drain;
  import gemm_dsp_pkg::*;

  localparam int LAT   = 4;
  localparam int DEPTH = 16;
  localparam int TILE  = 32;
  localparam int MAXC  = 4096;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic last_k = 1'b0;
  logic clr_flags = 1'b0;
  logic m_tready = 1'b0;
  logic signed [57:0] y_data = '0;

  logic [31:0] tdata0, tdata4;
  logic tvalid0, tvalid4, tlast0, tlast4;
  logic [4:0] lvl0, lvl4;
  logic sat0, sat4, ovf0, ovf4;

  always #5 clk = ~clk;

  dsp58_col_result_drain #(.SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .last_k(last_k),
    .y_data(y_data), .clr_flags(clr_flags),
    .m_tdata(tdata0), .m_tvalid(tvalid0),
    .m_tlast(tlast0), .m_tready(m_tready),
    .fifo_level(lvl0), .sat_flag(sat0),
    .ovf_err(ovf0)
  );

  dsp58_col_result_drain #(.SHIFT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .last_k(last_k),
    .y_data(y_data), .clr_flags(clr_flags),
    .m_tdata(tdata4), .m_tvalid(tvalid4),
    .m_tlast(tlast4), .m_tready(m_tready),
    .fifo_level(lvl4), .sat_flag(sat4),
    .ovf_err(ovf4)
  );

  typedef struct {
    result_t s0;
    result_t s4;
  } ent_t;

  typedef struct {
    longint      y;
    logic [31:0] e0;
    logic [31:0] e4;
    bit          s0;
    bit          s4;
  } vec_t;

  localparam int NV = 18;
  vec_t tv[NV];

  ent_t mq[$];
  ent_t st;
  bit   st_vld;
  bit   lkh[MAXC];
  bit   hasplan[MAXC];
  logic signed [57:0] yplan[MAXC];
  int   cyc, capcnt;
  bit   m_sat0, m_sat4, m_ovf;
  int   n_tests, n_fail;
  int   pops;
  int   last_at[$];

  function automatic longint ref_rnd(longint y, int sh);
    if (sh == 0) return y;
    return (y + (longint'(1) <<< (sh - 1))) >>> sh;
  endfunction

  function automatic bit ref_sat(longint r);
    return (r > MAXV) || (r < MINV);
  endfunction

  function automatic logic [31:0] ref_clip(longint r);
    if (r > MAXV) return 32'h7fff_ffff;
    if (r < MINV) return 32'h8000_0000;
    return r[31:0];
  endfunction

  function automatic longint rnd_y();
    logic [63:0] w;
    int sel;
    w = {$urandom, $urandom};
    sel = $urandom_range(0, 3);
    case (sel)
      0: return longint'($signed(w[11:0]));
      1: return longint'($signed(w[31:0]));
      2: return longint'($signed(w[36:0]));
      default: return longint'($signed(w[57:0]));
    endcase
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               nm, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive, compare against the model,
  // then advance the model across the clock edge.
  task automatic step(input bit lk, input longint v,
                      input bit tr, input bit clr);
    ent_t   e;
    bit     cap, pop, drop, cs0, cs4;
    longint yc, r0, r4;
    logic [63:0] junk;
    cs0 = 0; cs4 = 0; drop = 0;
    e = '{default: '0};
    last_k = lk; m_tready = tr; clr_flags = clr;
    lkh[cyc] = lk;
    if (lk) begin
      yplan[cyc + LAT] = v[57:0];
      hasplan[cyc + LAT] = 1'b1;
    end
    junk = {$urandom, $urandom};
    y_data = hasplan[cyc] ? yplan[cyc] : junk[57:0];
    hasplan[cyc] = 1'b0;

    chk("tvalid0", tvalid0, mq.size() > 0);
    chk("tvalid4", tvalid4, mq.size() > 0);
    chk("level0", lvl0, mq.size());
    chk("level4", lvl4, mq.size());
    chk("sat0", sat0, m_sat0);
    chk("sat4", sat4, m_sat4);
    chk("ovf0", ovf0, m_ovf);
    chk("ovf4", ovf4, m_ovf);
    if (mq.size() > 0) begin
      chk("data0", {32'h0, tdata0}, {32'h0, mq[0].s0.data});
      chk("data4", {32'h0, tdata4}, {32'h0, mq[0].s4.data});
      chk("last0", tlast0, mq[0].s0.last);
      chk("last4", tlast4, mq[0].s4.last);
    end
    if (tvalid0 && tr) begin
      if (tlast0) last_at.push_back(pops);
      pops++;
    end

    cap = (cyc >= LAT) && lkh[cyc - LAT];
    if (cap) begin
      yc = longint'(y_data);
      r0 = ref_rnd(yc, 0);
      r4 = ref_rnd(yc, 4);
      e.s0.last = (capcnt % TILE) == TILE - 1;
      e.s4.last = e.s0.last;
      e.s0.data = ref_clip(r0);
      e.s4.data = ref_clip(r4);
      cs0 = ref_sat(r0);
      cs4 = ref_sat(r4);
      capcnt++;
    end
    pop = (mq.size() > 0) && tr;

    @(posedge clk); #1;

    if (pop) void'(mq.pop_front());
    if (st_vld) begin
      if (mq.size() < DEPTH) mq.push_back(st);
      else drop = 1;
    end
    m_sat0 = (m_sat0 && !clr) || cs0;
    m_sat4 = (m_sat4 && !clr) || cs4;
    m_ovf  = (m_ovf && !clr) || drop;
    st_vld = cap;
    if (cap) st = e;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    last_k = 0; m_tready = 0; clr_flags = 0;
    #1;
    chk("rst_tvalid0", tvalid0, 0);
    chk("rst_tvalid4", tvalid4, 0);
    chk("rst_tlast0", tlast0, 0);
    chk("rst_tlast4", tlast4, 0);
    chk("rst_tdata0", tdata0, 0);
    chk("rst_tdata4", tdata4, 0);
    chk("rst_level0", lvl0, 0);
    chk("rst_level4", lvl4, 0);
    chk("rst_flags0", {sat0, ovf0}, 0);
    chk("rst_flags4", {sat4, ovf4}, 0);
    mq.delete();
    st_vld = 0; capcnt = 0;
    m_sat0 = 0; m_sat4 = 0; m_ovf = 0;
    for (int i = 0; i <= LAT; i++)
      if (cyc - i >= 0) lkh[cyc - i] = 0;
    repeat (2) begin
      lkh[cyc] = 0;
      @(posedge clk); #1;
      cyc++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; capcnt = 0;
    pops = 0; st_vld = 0;
    m_sat0 = 0; m_sat4 = 0; m_ovf = 0;
    st = '{default: '0};
    for (int i = 0; i < MAXC; i++) begin
      lkh[i] = 0; hasplan[i] = 0; yplan[i] = '0;
    end

    tv[0]  = '{123, 32'd123, 32'd8, 0, 0};
    tv[1]  = '{24, 32'd24, 32'd2, 0, 0};
    tv[2]  = '{-24, 32'hFFFF_FFE8, 32'hFFFF_FFFF, 0, 0};
    tv[3]  = '{23, 32'd23, 32'd1, 0, 0};
    tv[4]  = '{8, 32'd8, 32'd1, 0, 0};
    tv[5]  = '{-9, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 0, 0};
    tv[6]  = '{MAXV, 32'h7FFF_FFFF, 32'h0800_0000, 0, 0};
    tv[7]  = '{MINV, 32'h8000_0000, 32'hF800_0000, 0, 0};
    tv[8]  = '{MAXV + 1, 32'h7FFF_FFFF,
               32'h0800_0000, 1, 0};
    tv[9]  = '{MINV - 1, 32'h8000_0000,
               32'hF800_0000, 1, 0};
    tv[10] = '{(longint'(1) <<< 35) - 9,
               32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 0};
    tv[11] = '{(longint'(1) <<< 35) - 8,
               32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 1};
    tv[12] = '{-(longint'(1) <<< 35) - 8,
               32'h8000_0000, 32'h8000_0000, 1, 0};
    tv[13] = '{-(longint'(1) <<< 35) - 9,
               32'h8000_0000, 32'h8000_0000, 1, 1};
    tv[14] = '{longint'(1) <<< 40,
               32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 1};
    tv[15] = '{-(longint'(1) <<< 40),
               32'h8000_0000, 32'h8000_0000, 1, 1};
    tv[16] = '{(longint'(1) <<< 57) - 1,
               32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 1};
    tv[17] = '{-(longint'(1) <<< 57),
               32'h8000_0000, 32'h8000_0000, 1, 1};

    @(posedge clk); #1;
    do_reset();

    // single results: latency, rounding, saturation
    for (int i = 0; i < NV; i++) begin
      step(0, 0, 0, 1);
      step(1, tv[i].y, 0, 0);
      repeat (4) step(0, 0, 0, 0);
      chk("lat_early", tvalid0, 0);
      step(0, 0, 0, 0);
      chk("lat_valid", tvalid0, 1);
      chk("vec_d0", {32'h0, tdata0}, {32'h0, tv[i].e0});
      chk("vec_d4", {32'h0, tdata4}, {32'h0, tv[i].e4});
      chk("vec_sat0", sat0, tv[i].s0);
      chk("vec_sat4", sat4, tv[i].s4);
      chk("vec_last", tlast0, 0);
      step(0, 0, 1, 0);
    end
    step(0, 0, 0, 1);
    chk("clr_sat0", sat0, 0);
    chk("clr_sat4", sat4, 0);

    // clear coinciding with a saturation: set wins
    step(1, longint'(1) <<< 40, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("set_wins", sat0, 1);
    repeat (4) step(0, 0, 1, 0);

    // framing: 64 back-to-back results
    do_reset();
    pops = 0; last_at.delete();
    for (int i = 0; i < 64; i++) step(1, rnd_y(), 1, 0);
    repeat (6) step(0, 0, 1, 0);
    chk("frame_pops", pops, 64);
    chk("frame_nlast", last_at.size(), 2);
    chk("frame_last_a",
        last_at.size() > 0 ? last_at[0] : -1, 31);
    chk("frame_last_b",
        last_at.size() > 1 ? last_at[1] : -1, 63);

    // overflow under backpressure
    do_reset();
    for (int i = 0; i < 20; i++) step(1, rnd_y(), 0, 0);
    repeat (8) step(0, 0, 0, 0);
    chk("ovf_level", lvl0, 16);
    chk("ovf_err0", ovf0, 1);
    chk("ovf_err4", ovf4, 1);
    pops = 0;
    repeat (20) step(0, 0, 1, 0);
    chk("ovf_drain", pops, 16);

    // push and pop in the same cycle while full
    step(0, 0, 0, 1);
    for (int i = 0; i < 31; i++)
      step(i <= 16, rnd_y(), i == 21, 0);
    chk("full_pp_level", lvl0, 16);
    chk("full_pp_ovf", ovf0, 0);
    repeat (20) step(0, 0, 1, 0);

    // reset with 5 buffered and 2 in flight
    for (int i = 0; i < 5; i++) step(1, rnd_y(), 0, 0);
    repeat (6) step(0, 0, 0, 0);
    step(1, rnd_y(), 0, 0);
    step(1, rnd_y(), 0, 0);
    chk("mid_level", lvl0, 5);
    do_reset();
    pops = 0; last_at.delete();
    for (int i = 0; i < 40; i++) step(1, rnd_y(), 1, 0);
    repeat (6) step(0, 0, 1, 0);
    chk("mid_pops", pops, 40);
    chk("mid_nlast", last_at.size(), 1);
    chk("mid_last",
        last_at.size() > 0 ? last_at[0] : -1, 31);

    // random traffic against the model
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 2) != 0, rnd_y(),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0);
    repeat (30) step(0, 0, 1, 0);
    chk("final_level", lvl0, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
